// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Pipeline sequencing controller for the 5-stage RV32 core. It is the only
// source of the IF/ID/EXE stage register enables and flushes. It turns
// load-use stalls, taken branches/jumps, ecalls and data-memory busy into
// per-stage controls. It also sequences the ecall trap: drain the older
// instructions, then write mepc/mcause and redirect the PC to mtvec.
//
// Parameters
//   DRAIN_CYCLES  cycles waited after an ecall before the redirect (1..7)
//   ECALL_CAUSE   value presented on mcause_wdata
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   id_stall_req      load-use hazard in ID
//   id_ecall, id_pc   ecall in ID and its PC
//   exe_br_jmp        taken branch/jump resolved in EXE
//   exe_br_target     target of that branch/jump
//   mem_busy          data memory not ready; the whole pipeline holds
//   mtvec             trap vector from the CSR file
//   pc_we, if_id_we, id_exe_we      stage register write enables
//   if_id_flush, id_exe_flush       load NOP into the stage register
//   pc_redirect, pc_redirect_addr   load the PC from the given address
//   mepc_we/_wdata, mcause_we/_wdata  CSR trap writes
//   ctrl_state        current FSM state, for debug
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned  DRAIN_CYCLES = 2,
    parameter logic [31:0]  ECALL_CAUSE  = 32'd11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_stall_req,
    input  logic        id_ecall,
    input  logic [31:0] id_pc,
    input  logic        exe_br_jmp,
    input  logic [31:0] exe_br_target,
    input  logic        mem_busy,
    input  logic [31:0] mtvec,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        id_exe_we,
    output logic        if_id_flush,
    output logic        id_exe_flush,
    output logic        pc_redirect,
    output logic [31:0] pc_redirect_addr,
    output logic        mepc_we,
    output logic [31:0] mepc_wdata,
    output logic        mcause_we,
    output logic [31:0] mcause_wdata,
    output logic [1:0]  ctrl_state
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_TRAP_DRAIN = 2'd2,
        ST_TRAP_REDIR = 2'd3
    } state_e;

    // Control strobes bundled so each state can build them in one place.
    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_exe_we;
        logic if_id_flush;
        logic id_exe_flush;
        logic pc_redirect;
        logic mepc_we;
        logic mcause_we;
    } ctrl_t;

    localparam ctrl_t CTRL_HOLD = '{default: 1'b0};

    // Counter preload: drain_cnt counts down to zero, so one less than the
    // number of drain cycles.
    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 32'd1);

    state_e      state_q,     state_d;
    logic [2:0]  drain_cnt_q, drain_cnt_d;
    logic [31:0] mepc_q,      mepc_d;
    logic        ready_q,     ready_d;

    ctrl_t       ctrl_s;
    logic [31:0] redirect_addr_s;
    logic [31:0] mepc_wdata_s;

    // Normal-flow decode shared by RUN and by the MEM_WAIT exit cycle.
    // Priority: mem_busy, then branch (squashes ecall/stall), then ecall,
    // then load-use stall. A flush paired with an enable loads a NOP.
    function automatic ctrl_t run_ctrl(input logic busy,
                                       input logic br,
                                       input logic ecall,
                                       input logic stall);
        ctrl_t c;
        c = CTRL_HOLD;
        if (busy) begin
            c = CTRL_HOLD;
        end else if (br) begin
            c.pc_we        = 1'b1;
            c.if_id_we     = 1'b1;
            c.id_exe_we    = 1'b1;
            c.if_id_flush  = 1'b1;
            c.id_exe_flush = 1'b1;
            c.pc_redirect  = 1'b1;
        end else if (ecall) begin
            // Freeze fetch/decode, push a bubble behind the ecall.
            c.id_exe_we    = 1'b1;
            c.id_exe_flush = 1'b1;
        end else if (stall) begin
            c.id_exe_we    = 1'b1;
            c.id_exe_flush = 1'b1;
        end else begin
            c.pc_we        = 1'b1;
            c.if_id_we     = 1'b1;
            c.id_exe_we    = 1'b1;
        end
        return c;
    endfunction

    // State and trap-context registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= 3'd0;
            mepc_q      <= 32'd0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            mepc_q      <= mepc_d;
            ready_q     <= ready_d;
        end
    end

    // Next-state, drain counter and mepc capture.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        mepc_d      = mepc_q;
        ready_d     = 1'b1;
        if (!ready_q) begin
            // First cycle out of reset: outputs are muted, so the FSM must
            // not act on any request either.
            state_d = state_q;
        end else begin
            case (state_q)
                // MEM_WAIT leaves in the same cycle mem_busy drops, so it
                // shares the RUN decode.
                ST_RUN, ST_MEM_WAIT: begin
                    if (mem_busy) begin
                        state_d = ST_MEM_WAIT;
                    end else if (exe_br_jmp) begin
                        state_d = ST_RUN;
                    end else if (id_ecall) begin
                        state_d     = ST_TRAP_DRAIN;
                        mepc_d      = id_pc;
                        drain_cnt_d = DRAIN_INIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_TRAP_DRAIN: begin
                    if (mem_busy) begin
                        drain_cnt_d = drain_cnt_q;
                    end else if (drain_cnt_q == 3'd0) begin
                        state_d = ST_TRAP_REDIR;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 3'd1;
                    end
                end
                ST_TRAP_REDIR: begin
                    if (mem_busy) begin
                        state_d = ST_TRAP_REDIR;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Per-state control strobes and redirect/CSR data.
    always_comb begin
        ctrl_s          = CTRL_HOLD;
        redirect_addr_s = 32'd0;
        mepc_wdata_s    = 32'd0;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                ctrl_s = run_ctrl(mem_busy, exe_br_jmp, id_ecall, id_stall_req);
                if (ctrl_s.pc_redirect) begin
                    redirect_addr_s = exe_br_target;
                end else begin
                    redirect_addr_s = 32'd0;
                end
            end
            ST_TRAP_DRAIN: begin
                // EXE only holds bubbles here, so exe_br_jmp is ignored.
                if (mem_busy) begin
                    ctrl_s = CTRL_HOLD;
                end else begin
                    ctrl_s.id_exe_we    = 1'b1;
                    ctrl_s.id_exe_flush = 1'b1;
                end
            end
            ST_TRAP_REDIR: begin
                if (mem_busy) begin
                    ctrl_s = CTRL_HOLD;
                end else begin
                    ctrl_s.pc_we        = 1'b1;
                    ctrl_s.if_id_we     = 1'b1;
                    ctrl_s.id_exe_we    = 1'b1;
                    ctrl_s.if_id_flush  = 1'b1;
                    ctrl_s.id_exe_flush = 1'b1;
                    ctrl_s.pc_redirect  = 1'b1;
                    ctrl_s.mepc_we      = 1'b1;
                    ctrl_s.mcause_we    = 1'b1;
                    redirect_addr_s     = mtvec;
                    mepc_wdata_s        = mepc_q;
                end
            end
            default: begin
                ctrl_s = CTRL_HOLD;
            end
        endcase
    end

    // Output drive; everything but the debug state is muted until ready.
    always_comb begin
        pc_we            = 1'b0;
        if_id_we         = 1'b0;
        id_exe_we        = 1'b0;
        if_id_flush      = 1'b0;
        id_exe_flush     = 1'b0;
        pc_redirect      = 1'b0;
        pc_redirect_addr = 32'd0;
        mepc_we          = 1'b0;
        mepc_wdata       = 32'd0;
        mcause_we        = 1'b0;
        mcause_wdata     = 32'd0;
        if (ready_q) begin
            pc_we            = ctrl_s.pc_we;
            if_id_we         = ctrl_s.if_id_we;
            id_exe_we        = ctrl_s.id_exe_we;
            if_id_flush      = ctrl_s.if_id_flush;
            id_exe_flush     = ctrl_s.id_exe_flush;
            pc_redirect      = ctrl_s.pc_redirect;
            pc_redirect_addr = redirect_addr_s;
            mepc_we          = ctrl_s.mepc_we;
            mepc_wdata       = mepc_wdata_s;
            mcause_we        = ctrl_s.mcause_we;
            mcause_wdata     = ECALL_CAUSE;
        end else begin
            pc_we = 1'b0;
        end
    end

    assign ctrl_state = state_q;

endmodule
